axis_accum_sum: RTL and testbench

AXIS_ACCUM_SUM -- requirements
Module: axis_accum_sum

---
 rtl/axis_accum_sum.sv | 77 +++++++
 tb/tb_axis_accum_sum.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_accum_sum.sv
// AXI-Stream group accumulator: adds up to 2**SHIFT_BITS input beats (fewer when
// s_tlast closes a group early) and emits the sum with its beat count.
module axis_accum_sum #(
   parameter int DSIZE_IN   = 8,
   parameter int SHIFT_BITS = 2,
   parameter int SIGNED     = 0
) (
   input  logic                             clock,
   input  logic                             rst,
   input  logic [DSIZE_IN-1:0]              s_tdata,
   input  logic                             s_tvalid,
   input  logic                             s_tlast,
   output logic                             s_tready,
   output logic [DSIZE_IN+SHIFT_BITS-1:0]   m_tdata,
   output logic [SHIFT_BITS:0]              m_tcnt,
   output logic                             m_tvalid,
   output logic                             m_tlast,
   input  logic                             m_tready
);

   localparam int DSIZE_OUT = DSIZE_IN + SHIFT_BITS;
   localparam int CSIZE     = SHIFT_BITS + 1;
   localparam int ACC_NUM   = 2 ** SHIFT_BITS;
   localparam logic [CSIZE-1:0] LAST_CNT = CSIZE'(ACC_NUM - 1);

   logic [CSIZE-1:0]     cnt;
   logic [DSIZE_OUT-1:0] acc;
   logic [DSIZE_OUT-1:0] ext;
   logic [DSIZE_OUT-1:0] sum;
   logic                 closing;
   logic                 accept;

   // Widening by SHIFT_BITS guarantees a full group of full-scale samples never wraps.
   always_comb begin
      if (SIGNED != 0) begin
         ext = DSIZE_OUT'($signed(s_tdata));
      end else begin
         ext = DSIZE_OUT'(s_tdata);
      end
   end

   assign sum      = acc + ext;
   assign closing  = (cnt == LAST_CNT) || s_tlast;
   // Only a closing beat needs the output slot, so only it can be stalled.
   assign s_tready = !closing || !m_tvalid || m_tready;
   assign accept   = s_tvalid && s_tready;

   always_ff @(posedge clock) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         m_tdata  <= '0;
         m_tcnt   <= '0;
         m_tlast  <= 1'b0;
         m_tvalid <= 1'b0;
      end else begin
         if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
         end
         // A closing beat accepted while the slot drains reloads it with no bubble.
         if (accept) begin
            if (closing) begin
               m_tdata  <= sum;
               m_tcnt   <= cnt + CSIZE'(1);
               m_tlast  <= s_tlast;
               m_tvalid <= 1'b1;
               acc      <= '0;
               cnt      <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CSIZE'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_accum_sum.sv
// Directed self-checking bench for axis_accum_sum: unsigned and signed instances,
// back-pressure, early tlast, mid-group reset and a randomised scoreboard run.
module tb_axis_accum_sum;

   logic       clock = 1'b0;
   logic       rst;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;
   logic [9:0] m_tdata;
   logic [2:0] m_tcnt;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready;

   logic [7:0] g_s_tdata;
   logic       g_s_tvalid;
   logic       g_s_tlast;
   logic       g_s_tready;
   logic [9:0] g_m_tdata;
   logic [2:0] g_m_tcnt;
   logic       g_m_tvalid;
   logic       g_m_tlast;
   logic       g_m_tready;

   int checks = 0;
   int errors = 0;
   bit rand_done = 1'b0;

   logic [9:0] mon_data[$];
   logic [2:0] mon_cnt[$];
   logic       mon_last[$];

   always #5 clock = ~clock;

   axis_accum_sum #(.DSIZE_IN(8), .SHIFT_BITS(2), .SIGNED(0)) u_dut (
      .clock(clock), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tcnt(m_tcnt), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
      .m_tready(m_tready)
   );

   axis_accum_sum #(.DSIZE_IN(8), .SHIFT_BITS(2), .SIGNED(1)) u_signed (
      .clock(clock), .rst(rst),
      .s_tdata(g_s_tdata), .s_tvalid(g_s_tvalid), .s_tlast(g_s_tlast), .s_tready(g_s_tready),
      .m_tdata(g_m_tdata), .m_tcnt(g_m_tcnt), .m_tvalid(g_m_tvalid), .m_tlast(g_m_tlast),
      .m_tready(g_m_tready)
   );

   // Inputs settle 1 ns after posedge, so at negedge the upcoming handshake is already decided.
   always @(negedge clock) begin
      if (!rst && m_tvalid && m_tready) begin
         mon_data.push_back(m_tdata);
         mon_cnt.push_back(m_tcnt);
         mon_last.push_back(m_tlast);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge clock);
      while (!s_tready && n < 100) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (s_tready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL send_timeout: s_tready=%0b after %0d cycles, expected 1", s_tready, n);
      end
      @(posedge clock);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      @(negedge clock);
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %0b expected 0", m_tvalid); end
      checks++;
      if (m_tdata !== 10'd0) begin errors++; $display("[TB] FAIL reset_tdata: got %0d expected 0", m_tdata); end
      checks++;
      if (m_tcnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_tcnt: got %0d expected 0", m_tcnt); end
      checks++;
      if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %0b expected 0", m_tlast); end
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready: got %0b expected 1", s_tready); end
      checks++;
      if (g_m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_signed_tvalid: got %0b expected 0", g_m_tvalid); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int base;
      base = mon_data.size();
      m_tready = 1'b1;
      send_beat(8'd1, 1'b0);
      send_beat(8'd2, 1'b0);
      send_beat(8'd3, 1'b0);
      send_beat(8'd4, 1'b0);
      @(negedge clock);
      checks++;
      if (m_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency_tvalid: got %0b expected 1", m_tvalid); end
      checks++;
      if (m_tdata !== 10'd10) begin errors++; $display("[TB] FAIL basic_tdata: got %0d expected 10", m_tdata); end
      checks++;
      if (m_tcnt !== 3'd4) begin errors++; $display("[TB] FAIL basic_tcnt: got %0d expected 4", m_tcnt); end
      checks++;
      if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL basic_tlast: got %0b expected 0", m_tlast); end
      step();
      @(negedge clock);
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_tvalid_clear: got %0b expected 0", m_tvalid); end
      checks++;
      if (mon_data.size() - base != 1) begin
         errors++;
         $display("[TB] FAIL basic_beat_count: got %0d beats expected 1", mon_data.size() - base);
      end
      step();
   endtask

   task automatic test_full_scale();
      int base;
      base = mon_data.size();
      m_tready = 1'b1;
      send_beat(8'd255, 1'b0);
      send_beat(8'd255, 1'b1);
      repeat (4) send_beat(8'd255, 1'b0);
      repeat (2) step();
      checks++;
      if (mon_data.size() - base != 2) begin
         errors++;
         $display("[TB] FAIL full_beat_count: got %0d beats expected 2", mon_data.size() - base);
      end else begin
         checks++;
         if (mon_data[base] !== 10'd510 || mon_cnt[base] !== 3'd2 || mon_last[base] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_tlast_group: got %0d/%0d/%0b expected 510/2/1",
                     mon_data[base], mon_cnt[base], mon_last[base]);
         end
         checks++;
         if (mon_data[base+1] !== 10'd1020 || mon_cnt[base+1] !== 3'd4 || mon_last[base+1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_no_wrap: got %0d/%0d/%0b expected 1020/4/0",
                     mon_data[base+1], mon_cnt[base+1], mon_last[base+1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base;
      base = mon_data.size();
      m_tready = 1'b0;
      send_beat(8'd1, 1'b0);
      send_beat(8'd2, 1'b0);
      send_beat(8'd3, 1'b0);
      send_beat(8'd4, 1'b0);
      repeat (3) send_beat(8'd5, 1'b0);
      s_tdata  = 8'd5;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL stall_tready[%0d]: got %0b expected 0", i, s_tready); end
         checks++;
         if (m_tvalid !== 1'b1 || m_tdata !== 10'd10 || m_tcnt !== 3'd4) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got v=%0b d=%0d c=%0d expected v=1 d=10 c=4", i, m_tvalid, m_tdata, m_tcnt);
         end
      end
      @(posedge clock);
      #1;
      m_tready = 1'b1;
      @(negedge clock);
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL release_tready: got %0b expected 1", s_tready); end
      @(posedge clock);
      #1;
      s_tvalid = 1'b0;
      @(negedge clock);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 10'd20 || m_tcnt !== 3'd4) begin
         errors++;
         $display("[TB] FAIL no_bubble_reload: got v=%0b d=%0d c=%0d expected v=1 d=20 c=4", m_tvalid, m_tdata, m_tcnt);
      end
      repeat (2) step();
      checks++;
      if (mon_data.size() - base != 2) begin
         errors++;
         $display("[TB] FAIL b2b_beat_count: got %0d beats expected 2", mon_data.size() - base);
      end else begin
         checks++;
         if (mon_data[base] !== 10'd10 || mon_data[base+1] !== 10'd20) begin
            errors++;
            $display("[TB] FAIL b2b_order: got %0d,%0d expected 10,20", mon_data[base], mon_data[base+1]);
         end
      end
   endtask

   task automatic test_tlast_boundary();
      int base;
      base = mon_data.size();
      m_tready = 1'b1;
      repeat (3) send_beat(8'd1, 1'b0);
      send_beat(8'd1, 1'b1);
      send_beat(8'd9, 1'b1);
      repeat (2) step();
      checks++;
      if (mon_data.size() - base != 2) begin
         errors++;
         $display("[TB] FAIL boundary_beat_count: got %0d beats expected 2", mon_data.size() - base);
      end else begin
         checks++;
         if (mon_data[base] !== 10'd4 || mon_cnt[base] !== 3'd4 || mon_last[base] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_full_tlast: got %0d/%0d/%0b expected 4/4/1",
                     mon_data[base], mon_cnt[base], mon_last[base]);
         end
         checks++;
         if (mon_data[base+1] !== 10'd9 || mon_cnt[base+1] !== 3'd1 || mon_last[base+1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL boundary_single: got %0d/%0d/%0b expected 9/1/1",
                     mon_data[base+1], mon_cnt[base+1], mon_last[base+1]);
         end
      end
   endtask

   task automatic test_reset_mid_group();
      int base;
      base = mon_data.size();
      m_tready = 1'b1;
      send_beat(8'd7, 1'b0);
      send_beat(8'd7, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (4) send_beat(8'd1, 1'b0);
      repeat (3) step();
      checks++;
      if (mon_data.size() - base != 1) begin
         errors++;
         $display("[TB] FAIL midreset_beat_count: got %0d beats expected 1", mon_data.size() - base);
      end else begin
         checks++;
         if (mon_data[base] !== 10'd4 || mon_cnt[base] !== 3'd4) begin
            errors++;
            $display("[TB] FAIL midreset_sum: got %0d/%0d expected 4/4", mon_data[base], mon_cnt[base]);
         end
      end
   endtask

   task automatic test_signed();
      logic [7:0] neg[4];
      logic [7:0] alt[4];
      neg = '{8'h80, 8'h80, 8'h80, 8'h80};
      alt = '{8'hFF, 8'h01, 8'hFF, 8'h01};
      g_m_tready = 1'b1;
      g_s_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         g_s_tdata = neg[i];
         step();
      end
      g_s_tvalid = 1'b0;
      @(negedge clock);
      checks++;
      if (g_m_tvalid !== 1'b1 || g_m_tdata !== 10'h200 || g_m_tcnt !== 3'd4) begin
         errors++;
         $display("[TB] FAIL signed_min: got v=%0b d=%h c=%0d expected v=1 d=200 c=4", g_m_tvalid, g_m_tdata, g_m_tcnt);
      end
      step();
      g_s_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         g_s_tdata = alt[i];
         step();
      end
      g_s_tvalid = 1'b0;
      @(negedge clock);
      checks++;
      if (g_m_tvalid !== 1'b1 || g_m_tdata !== 10'h000 || g_m_tcnt !== 3'd4) begin
         errors++;
         $display("[TB] FAIL signed_cancel: got v=%0b d=%h c=%0d expected v=1 d=000 c=4", g_m_tvalid, g_m_tdata, g_m_tcnt);
      end
      step();
   endtask

   task automatic test_random();
      int         base;
      int         acc;
      int         n;
      int         nout;
      logic [7:0] d;
      logic       l;
      logic [9:0] exp_data[$];
      logic [2:0] exp_cnt[$];
      logic       exp_last[$];
      base = mon_data.size();
      acc  = 0;
      n    = 0;
      rand_done = 1'b0;
      fork
         begin
            while (!rand_done) begin
               m_tready = ($urandom_range(0, 3) != 0);
               step();
            end
            m_tready = 1'b1;
         end
         begin
            for (int i = 0; i < 80; i++) begin
               d = 8'($urandom_range(0, 255));
               l = ($urandom_range(0, 4) == 0);
               if ($urandom_range(0, 3) == 0) step();
               send_beat(d, l);
               acc += int'(d);
               n++;
               if (n == 4 || l) begin
                  exp_data.push_back(10'(acc));
                  exp_cnt.push_back(3'(n));
                  exp_last.push_back(l);
                  acc = 0;
                  n   = 0;
               end
            end
            send_beat(8'd0, 1'b1);
            exp_data.push_back(10'(acc));
            exp_cnt.push_back(3'(n + 1));
            exp_last.push_back(1'b1);
            rand_done = 1'b1;
         end
      join
      repeat (4) step();
      nout = mon_data.size() - base;
      checks++;
      if (nout != exp_data.size()) begin
         errors++;
         $display("[TB] FAIL random_beat_count: got %0d beats expected %0d", nout, exp_data.size());
      end
      for (int k = 0; k < nout && k < exp_data.size(); k++) begin
         checks++;
         if (mon_data[base+k] !== exp_data[k] || mon_cnt[base+k] !== exp_cnt[k] || mon_last[base+k] !== exp_last[k]) begin
            errors++;
            $display("[TB] FAIL random_beat[%0d]: got %0d/%0d/%0b expected %0d/%0d/%0b", k,
                     mon_data[base+k], mon_cnt[base+k], mon_last[base+k], exp_data[k], exp_cnt[k], exp_last[k]);
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      s_tdata    = '0;
      s_tvalid   = 1'b0;
      s_tlast    = 1'b0;
      m_tready   = 1'b0;
      g_s_tdata  = '0;
      g_s_tvalid = 1'b0;
      g_s_tlast  = 1'b0;
      g_m_tready = 1'b1;
      $display("[TB] starting axis_accum_sum bench");
      test_reset();
      test_basic();
      test_full_scale();
      test_back_to_back();
      test_tlast_boundary();
      test_reset_mid_group();
      test_signed();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
